// File: rtl/memory_responder.sv
// Multi-channel memory responder: each channel runs an IDLE/BUSY/RESP/DRAIN FSM
// and completes one read or write after a fixed latency against shared storage.
module memory_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              host_write_valid,
    input  logic [ADDR_BITS-1:0]              host_write_address,
    input  logic [DATA_BITS-1:0]              host_write_data,
    output logic [NUM_CHANNELS-1:0]           channel_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [NUM_CHANNELS-1:0]                commit;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] commit_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] commit_data;

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        state_t               state_reg, state_next;
        logic [3:0]           count_reg, count_next;
        logic [ADDR_BITS-1:0] addr_reg, addr_next;
        logic [DATA_BITS-1:0] wdata_reg, wdata_next;
        logic                 is_write_reg, is_write_next;
        logic [DATA_BITS-1:0] rdata_reg;
        logic                 done;
        logic                 rd_v, wr_v;

        assign rd_v = mem_read_valid[gi];
        assign wr_v = mem_write_valid[gi];

        // done marks the completion edge; the *_next values then describe the
        // request being completed (freshly latched when latency is 1).
        always_comb begin
            state_next    = state_reg;
            count_next    = count_reg;
            addr_next     = addr_reg;
            wdata_next    = wdata_reg;
            is_write_next = is_write_reg;
            done          = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rd_v || wr_v) begin
                        is_write_next = !rd_v;
                        addr_next     = rd_v ? mem_read_address[gi*ADDR_BITS +: ADDR_BITS]
                                             : mem_write_address[gi*ADDR_BITS +: ADDR_BITS];
                        wdata_next    = mem_write_data[gi*DATA_BITS +: DATA_BITS];
                        count_next    = rd_v ? RD_LOAD : WR_LOAD;
                        if (count_next == 4'd0) begin
                            state_next = RESP;
                            done       = 1'b1;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (count_reg == 4'd0) begin
                        state_next = RESP;
                        done       = 1'b1;
                    end else begin
                        count_next = count_reg - 4'd1;
                    end
                end
                RESP:    state_next = (rd_v || wr_v) ? DRAIN : IDLE;
                DRAIN:   state_next = (rd_v || wr_v) ? DRAIN : IDLE;
                default: state_next = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_reg    <= IDLE;
                count_reg    <= 4'd0;
                addr_reg     <= '0;
                wdata_reg    <= '0;
                is_write_reg <= 1'b0;
                rdata_reg    <= '0;
            end else begin
                state_reg    <= state_next;
                count_reg    <= count_next;
                addr_reg     <= addr_next;
                wdata_reg    <= wdata_next;
                is_write_reg <= is_write_next;
                // Sampled before this edge's storage write lands
                if (done && !is_write_next)
                    rdata_reg <= mem[addr_next];
            end
        end

        assign commit[gi]      = done && is_write_next && (WRITE_ENABLE != 0) && reset;
        assign commit_addr[gi] = addr_next;
        assign commit_data[gi] = wdata_next;

        assign mem_read_ready[gi]  = (state_reg == RESP) && !is_write_reg;
        assign mem_write_ready[gi] = (state_reg == RESP) && is_write_reg;
        assign channel_busy[gi]    = (state_reg != IDLE);
        assign mem_read_data[gi*DATA_BITS +: DATA_BITS] = rdata_reg;
    end

    // Later assignments win: host lowest, then channels in ascending index
    always_comb begin
        wr_en   = host_write_valid;
        wr_addr = host_write_address;
        wr_data = host_write_data;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (commit[i]) begin
                wr_en   = 1'b1;
                wr_addr = commit_addr[i];
                wr_data = commit_data[i];
            end
        end
    end

    // Storage deliberately has no reset so contents survive it
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: one instance with writes enabled and
// one with WRITE_ENABLE=0 share all stimulus; completions are checked per channel.
module tb_memory_responder;

    localparam int RL = 2;
    localparam int WL = 2;

    typedef struct {
        int          ch;
        bit          is_wr;
        int          due;
        logic [15:0] exp;
        logic [15:0] exp0;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rv, wv;
    logic [31:0] ra, wa;
    logic [63:0] wd;
    logic        hv;
    logic [7:0]  ha;
    logic [15:0] hd;
    logic [3:0]  rrdy, wrdy, busy;
    logic [3:0]  rrdy0, wrdy0, busy0;
    logic [63:0] rdata, rdata0;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    txn_t sb[$];

    memory_responder #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(4),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(rst_n),
        .mem_read_valid(rv), .mem_read_address(ra),
        .mem_read_ready(rrdy), .mem_read_data(rdata),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd),
        .mem_write_ready(wrdy),
        .host_write_valid(hv), .host_write_address(ha), .host_write_data(hd),
        .channel_busy(busy)
    );

    memory_responder #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(4),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(0)
    ) dut_we0 (
        .clk(clk), .reset(rst_n),
        .mem_read_valid(rv), .mem_read_address(ra),
        .mem_read_ready(rrdy0), .mem_read_data(rdata0),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd),
        .mem_write_ready(wrdy0),
        .host_write_valid(hv), .host_write_address(ha), .host_write_data(hd),
        .channel_busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_txn(input int ch, input bit is_wr, input int lat,
                            input logic [15:0] e, input logic [15:0] e0);
        txn_t t;
        t.ch = ch; t.is_wr = is_wr; t.due = cyc + 1 + lat; t.exp = e; t.exp0 = e0;
        sb.push_back(t);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        hv = 1'b1; ha = a; hd = d;
        @(negedge clk);
        hv = 1'b0;
    endtask

    // Issue one request, scramble inputs once accepted, hold valid `hold`
    // cycles past the ready cycle, then drop it and expect IDLE.
    task automatic run_req(input int ch, input bit rd, input bit wr,
                           input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] e, input logic [15:0] e0, input int hold);
        int lat;
        lat = rd ? RL : WL;
        @(negedge clk);
        if (rd) begin rv[ch] = 1'b1; ra[ch*8 +: 8] = a; end
        if (wr) begin wv[ch] = 1'b1; wa[ch*8 +: 8] = a; wd[ch*16 +: 16] = d; end
        push_txn(ch, !rd, lat, e, e0);
        @(negedge clk);
        check_val("busy_after_accept", 32'(busy[ch]), 32'd1);
        ra[ch*8 +: 8]   = ~a;
        wa[ch*8 +: 8]   = ~a;
        wd[ch*16 +: 16] = ~d;
        repeat (lat - 1 + hold) @(negedge clk);
        if (hold > 0) check_val("busy_while_held", 32'(busy[ch]), 32'd1);
        rv[ch] = 1'b0;
        wv[ch] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("busy_back_idle", 32'(busy[ch]), 32'd0);
    endtask

    // Completion monitor: every ready pulse must match the oldest entry of its channel
    always @(negedge clk) begin
        int   idx;
        txn_t t;
        for (int ch = 0; ch < 4; ch++) begin
            idx = -1;
            for (int k = 0; k < sb.size(); k++)
                if (idx < 0 && sb[k].ch == ch) idx = k;
            if (idx >= 0 && sb[idx].due == cyc) begin
                t = sb[idx];
                sb.delete(idx);
                check_val("ready_kind", 32'({rrdy[ch], wrdy[ch]}), 32'({!t.is_wr, t.is_wr}));
                check_val("ready_kind_we0", 32'({rrdy0[ch], wrdy0[ch]}), 32'({!t.is_wr, t.is_wr}));
                if (!t.is_wr) begin
                    check_val("read_data", 32'(rdata[ch*16 +: 16]), 32'(t.exp));
                    check_val("read_data_we0", 32'(rdata0[ch*16 +: 16]), 32'(t.exp0));
                end
                $display("txn ch%0d %s cyc=%0d data=%h data_we0=%h", ch, t.is_wr ? "write" : "read ",
                         cyc, rdata[ch*16 +: 16], rdata0[ch*16 +: 16]);
            end else if (rrdy[ch] || wrdy[ch] || rrdy0[ch] || wrdy0[ch]) begin
                check_val("unexpected_ready", 32'({rrdy[ch], wrdy[ch], rrdy0[ch], wrdy0[ch]}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        hv = 1'b0; ha = '0; hd = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'({rrdy, wrdy}), 32'd0);
        check_val("rst_rdata_lo", rdata[31:0], 32'd0);
        check_val("rst_rdata_hi", rdata[63:32], 32'd0);
        check_val("rst_busy_we0", 32'(busy0), 32'd0);
        rst_n = 1'b1;

        // Basic read of a preloaded word, valid held one cycle past ready
        host_write(8'h10, 16'hBEEF);
        run_req(0, 1'b1, 1'b0, 8'h10, 16'h0, 16'hBEEF, 16'hBEEF, 1);

        // Write then read back; the WRITE_ENABLE=0 copy keeps the preload
        host_write(8'h22, 16'h00AA);
        run_req(1, 1'b0, 1'b1, 8'h22, 16'h1234, 16'h0, 16'h0, 0);
        run_req(1, 1'b1, 1'b0, 8'h22, 16'h0, 16'h1234, 16'h00AA, 0);

        // Same-edge conflict: ch3 beats ch0 beats the host write
        host_write(8'h05, 16'h0F0F);
        @(negedge clk);
        wv[0] = 1'b1; wa[7:0]   = 8'h05; wd[15:0]  = 16'hAAAA;
        wv[3] = 1'b1; wa[31:24] = 8'h05; wd[63:48] = 16'h5555;
        push_txn(0, 1'b1, WL, 16'h0, 16'h0);
        push_txn(3, 1'b1, WL, 16'h0, 16'h0);
        repeat (WL) @(negedge clk);
        hv = 1'b1; ha = 8'h05; hd = 16'h0000;
        @(negedge clk);
        hv = 1'b0; wv[0] = 1'b0; wv[3] = 1'b0;
        @(negedge clk);
        run_req(1, 1'b1, 1'b0, 8'h05, 16'h0, 16'h5555, 16'h0000, 0);

        // Valid held six cycles after ready: one pulse only
        host_write(8'h60, 16'h6006);
        run_req(2, 1'b1, 1'b0, 8'h60, 16'h0, 16'h6006, 16'h6006, 6);

        // Read and write together: the read wins, storage untouched
        host_write(8'h40, 16'h4040);
        run_req(2, 1'b1, 1'b1, 8'h40, 16'hDEAD, 16'h4040, 16'h4040, 0);
        run_req(2, 1'b1, 1'b0, 8'h40, 16'h0, 16'h4040, 16'h4040, 0);

        // All four channels reading concurrently
        for (int i = 0; i < 4; i++) host_write(8'(8'h80 + i), 16'(16'h1000 * (i + 1) + i));
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b1;
            ra[i*8 +: 8] = 8'(8'h80 + i);
            push_txn(i, 1'b0, RL, 16'(16'h1000 * (i + 1) + i), 16'(16'h1000 * (i + 1) + i));
        end
        repeat (RL + 1) @(negedge clk);
        rv = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("parallel_idle", 32'(busy), 32'd0);

        // Reset during BUSY abandons the write; a held valid is taken after release
        host_write(8'h30, 16'h0101);
        @(negedge clk);
        wv[0] = 1'b1; wa[7:0] = 8'h30; wd[15:0] = 16'h7777;
        @(negedge clk);
        check_val("midop_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midop_rst_busy", 32'(busy), 32'd0);
        check_val("midop_rst_ready", 32'({rrdy, wrdy}), 32'd0);
        check_val("midop_rst_rdata", rdata[31:0], 32'd0);
        wv[0] = 1'b0;
        rv[1] = 1'b1; ra[15:8] = 8'h30;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_txn(1, 1'b0, RL, 16'h0101, 16'h0101);
        repeat (RL + 1) @(negedge clk);
        rv[1] = 1'b0;
        repeat (5) @(negedge clk);
        check_val("final_idle", 32'(busy), 32'd0);
        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
